// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared types and constants for the mem_ctrl memory front end
// Rev 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  SIZE_BYTE         = 2'd1;
    localparam logic [1:0]  SIZE_WORD         = 2'd2;
    localparam logic [15:0] RAM_LIMIT_DEFAULT = 16'h0800;

    // Byte reads keep the low byte and optionally sign-extend it.
    function automatic logic [15:0] format_read(input logic [1:0]  size,
                                                input logic        sign_ext,
                                                input logic [15:0] raw);
        if (size == SIZE_WORD) begin
            return raw;
        end
        return {{8{sign_ext & raw[7]}}, raw[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arb.sv
`default_nettype none
// ============================================================================
// mem_rr_arb : two-way round-robin arbiter, bit 0 = fetch, bit 1 = data
// Rev 1.0
// ============================================================================
module mem_rr_arb #(
    parameter bit FETCH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_last_fetch;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last_fetch ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_fetch <= !FETCH_FIRST;
        end else if (advance && (grant != 2'b00)) begin
            r_last_fetch <= grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : arbitrates fetch and data ports onto a single RAM stage
// Rev 1.0
// ============================================================================
module mem_ctrl
    import mem_pkg::*;
#(
    parameter logic [15:0] RAM_LIMIT   = RAM_LIMIT_DEFAULT,
    parameter int          FETCH_FIRST = 1
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_f_req,
    input  logic [15:0] I_f_addr,
    output logic        O_f_ack,
    output logic [15:0] O_f_data,
    output logic        O_f_err,
    input  logic        I_d_req,
    input  logic        I_d_write,
    input  logic [1:0]  I_d_size,
    input  logic        I_d_signed,
    input  logic [15:0] I_d_addr,
    input  logic [15:0] I_d_wdata,
    output logic        O_d_ack,
    output logic [15:0] O_d_data,
    output logic        O_d_err,
    output logic        O_ram_enable,
    output logic        O_ram_write,
    output logic [1:0]  O_ram_size,
    output logic [15:0] O_ram_addr,
    output logic [15:0] O_ram_data,
    input  logic [15:0] I_ram_data
);

    state_t      r_state;
    logic        r_sel_data;
    logic        r_write;
    logic        r_signed;
    logic [1:0]  r_size;

    logic [1:0]  w_grant;
    logic        w_sel_data;
    logic [15:0] w_addr;
    logic [1:0]  w_size;
    logic        w_write;
    logic        w_signed;
    logic        w_valid;

    mem_rr_arb #(
        .FETCH_FIRST (FETCH_FIRST != 0)
    ) u_arb (
        .clk     (I_clk),
        .rst     (I_reset),
        .req     ({I_d_req, I_f_req}),
        .advance (r_state == IDLE),
        .grant   (w_grant)
    );

    // Fetches are always word reads; data sizes other than word collapse to byte.
    assign w_sel_data = w_grant[1];
    assign w_addr     = w_sel_data ? I_d_addr : I_f_addr;
    assign w_size     = (w_sel_data && (I_d_size != SIZE_WORD)) ? SIZE_BYTE : SIZE_WORD;
    assign w_write    = w_sel_data & I_d_write;
    assign w_signed   = w_sel_data & I_d_signed;
    assign w_valid    = (w_addr < RAM_LIMIT);

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state      <= IDLE;
            r_sel_data   <= 1'b0;
            r_write      <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= 2'd0;
            O_f_ack      <= 1'b0;
            O_f_data     <= 16'h0000;
            O_f_err      <= 1'b0;
            O_d_ack      <= 1'b0;
            O_d_data     <= 16'h0000;
            O_d_err      <= 1'b0;
            O_ram_enable <= 1'b0;
            O_ram_write  <= 1'b0;
            O_ram_size   <= 2'd0;
            O_ram_addr   <= 16'h0000;
            O_ram_data   <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_sel_data <= w_sel_data;
                        r_size     <= w_size;
                        r_write    <= w_write;
                        r_signed   <= w_signed;
                        if (w_valid) begin
                            r_state      <= ISSUE;
                            O_ram_enable <= 1'b1;
                            O_ram_write  <= w_write;
                            O_ram_size   <= w_size;
                            O_ram_addr   <= w_addr;
                            O_ram_data   <= w_write ? I_d_wdata : 16'h0000;
                        end else begin
                            // Out-of-range access answers immediately, RAM untouched.
                            r_state  <= RESP;
                            O_f_ack  <= !w_sel_data;
                            O_f_err  <= !w_sel_data;
                            O_d_ack  <= w_sel_data;
                            O_d_err  <= w_sel_data;
                            O_f_data <= 16'h0000;
                            O_d_data <= 16'h0000;
                        end
                    end
                end
                ISSUE: begin
                    O_ram_enable <= 1'b0;
                    O_ram_write  <= 1'b0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (r_sel_data) begin
                        O_d_ack  <= 1'b1;
                        O_d_data <= r_write ? 16'h0000
                                            : format_read(r_size, r_signed, I_ram_data);
                    end else begin
                        O_f_ack  <= 1'b1;
                        O_f_data <= I_ram_data;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    O_f_ack  <= 1'b0;
                    O_f_err  <= 1'b0;
                    O_f_data <= 16'h0000;
                    O_d_ack  <= 1'b0;
                    O_d_err  <= 1'b0;
                    O_d_data <= 16'h0000;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : directed self-checking bench for mem_ctrl with a byte RAM model
// Rev 1.0
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [15:0] f_data;
    logic        f_err;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_data;
    logic        d_err;
    logic        ram_enable;
    logic        ram_write;
    logic [1:0]  ram_size;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int errors = 0;
    int checks = 0;
    int double_ack = 0;

    logic [7:0] mem [0:65535];

    mem_ctrl dut (
        .I_clk        (clk),
        .I_reset      (reset),
        .I_f_req      (f_req),
        .I_f_addr     (f_addr),
        .O_f_ack      (f_ack),
        .O_f_data     (f_data),
        .O_f_err      (f_err),
        .I_d_req      (d_req),
        .I_d_write    (d_write),
        .I_d_size     (d_size),
        .I_d_signed   (d_signed),
        .I_d_addr     (d_addr),
        .I_d_wdata    (d_wdata),
        .O_d_ack      (d_ack),
        .O_d_data     (d_data),
        .O_d_err      (d_err),
        .O_ram_enable (ram_enable),
        .O_ram_write  (ram_write),
        .O_ram_size   (ram_size),
        .O_ram_addr   (ram_addr),
        .O_ram_data   (ram_wdata),
        .I_ram_data   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Little-endian byte RAM; read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_write) begin
                mem[ram_addr] <= ram_wdata[7:0];
                if (ram_size == 2'd2) mem[ram_addr + 16'd1] <= ram_wdata[15:8];
            end else begin
                ram_rdata <= {mem[ram_addr + 16'd1], mem[ram_addr]};
            end
        end
    end

    always @(negedge clk) if (f_ack && d_ack) double_ack++;

    function automatic logic [71:0] all_outs();
        return {f_ack, f_err, f_data, d_ack, d_err, d_data,
                ram_enable, ram_write, ram_size, ram_addr, ram_wdata};
    endfunction

    // Runs one access on the chosen port; lat counts cycles from grant edge to ack, -1 on timeout.
    task automatic xact(input bit dport, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output logic er, output int lat,
                        output bit saw_en);
        bit got;
        @(negedge clk);
        if (dport) begin
            d_req = 1'b1; d_write = wr; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = a;
        end
        lat = 0; saw_en = 1'b0; rd = 16'h0; er = 1'b0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (ram_enable) saw_en = 1'b1;
            if (dport ? d_ack : f_ack) begin
                rd  = dport ? d_data : f_data;
                er  = dport ? d_err : f_err;
                got = 1'b1;
                break;
            end
        end
        if (!got) lat = -1;
        f_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        reset = 1'b1; f_req = 1'b1; f_addr = 16'h0010;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== 72'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        reset = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (f_ack) begin lat = i; break; end
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL reset_first_grant_latency: got %0d want 3", lat); end
        checks++;
        if (f_data !== 16'h1234) begin errors++; $display("FAIL reset_first_fetch_data: got %h want 1234", f_data); end
        f_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({ram_enable, ram_write, ram_size, ram_addr} !== {1'b1, 1'b0, 2'd2, 16'h0010}) begin
            errors++;
            $display("FAIL fetch_issue: got en=%b wr=%b sz=%0d addr=%h want en=1 wr=0 sz=2 addr=0010",
                     ram_enable, ram_write, ram_size, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({f_ack, ram_enable} !== 2'b00) begin
            errors++; $display("FAIL fetch_wait: got ack=%b en=%b want 0 0", f_ack, ram_enable);
        end
        @(negedge clk);
        checks++;
        if ({f_ack, f_err, f_data, d_ack} !== {1'b1, 1'b0, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL fetch_ack: got ack=%b err=%b data=%h d_ack=%b want 1 0 1234 0",
                     f_ack, f_err, f_data, d_ack);
        end
        f_req = 1'b0;
        @(negedge clk);
        checks++;
        if (f_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse: got %b want 0", f_ack); end
    endtask

    task automatic test_byte_reads();
        logic [15:0] rd; logic er; int lat; bit en;
        mem[16'h0020] = 8'h80; mem[16'h0021] = 8'h55; mem[16'h0022] = 8'h7F; mem[16'h0023] = 8'h99;
        xact(1'b1, 1'b0, 2'd1, 1'b1, 16'h0020, 16'h0, rd, er, lat, en);
        checks++;
        if ({rd, er, lat} !== {16'hFF80, 1'b0, 32'd3}) begin
            errors++; $display("FAIL signed_byte: got %h err=%b lat=%0d want ff80 0 3", rd, er, lat);
        end
        xact(1'b1, 1'b0, 2'd1, 1'b0, 16'h0020, 16'h0, rd, er, lat, en);
        checks++;
        if (rd !== 16'h0080) begin errors++; $display("FAIL unsigned_byte: got %h want 0080", rd); end
        xact(1'b1, 1'b0, 2'd3, 1'b1, 16'h0020, 16'h0, rd, er, lat, en);
        checks++;
        if (rd !== 16'hFF80) begin errors++; $display("FAIL size3_as_byte: got %h want ff80", rd); end
        xact(1'b1, 1'b0, 2'd0, 1'b0, 16'h0021, 16'h0, rd, er, lat, en);
        checks++;
        if (rd !== 16'h0055) begin errors++; $display("FAIL size0_as_byte: got %h want 0055", rd); end
        xact(1'b1, 1'b0, 2'd1, 1'b1, 16'h0022, 16'h0, rd, er, lat, en);
        checks++;
        if (rd !== 16'h007F) begin errors++; $display("FAIL signed_positive_byte: got %h want 007f", rd); end
    endtask

    task automatic test_write_read();
        logic [15:0] rd; logic er; int lat; bit en;
        mem[16'h0103] = 8'h00;
        xact(1'b1, 1'b1, 2'd2, 1'b0, 16'h0100, 16'hBEEF, rd, er, lat, en);
        checks++;
        if ({rd, er, lat, en} !== {16'h0000, 1'b0, 32'd3, 1'b1}) begin
            errors++; $display("FAIL word_write_ack: got %h err=%b lat=%0d en=%b want 0000 0 3 1", rd, er, lat, en);
        end
        xact(1'b1, 1'b0, 2'd2, 1'b0, 16'h0100, 16'h0, rd, er, lat, en);
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL word_readback: got %h want beef", rd); end
        xact(1'b1, 1'b1, 2'd1, 1'b0, 16'h0102, 16'hAA11, rd, er, lat, en);
        xact(1'b1, 1'b0, 2'd2, 1'b0, 16'h0102, 16'h0, rd, er, lat, en);
        checks++;
        if (rd !== 16'h0011) begin errors++; $display("FAIL byte_write_readback: got %h want 0011", rd); end
    endtask

    task automatic test_errors();
        logic [15:0] rd; logic er; int lat; bit en;
        mem[16'h07FF] = 8'hCD; mem[16'h0800] = 8'hAB;
        xact(1'b1, 1'b0, 2'd1, 1'b0, 16'h0800, 16'h0, rd, er, lat, en);
        checks++;
        if ({rd, er, lat, en} !== {16'h0000, 1'b1, 32'd1, 1'b0}) begin
            errors++; $display("FAIL data_read_limit_err: got %h err=%b lat=%0d en=%b want 0000 1 1 0", rd, er, lat, en);
        end
        xact(1'b1, 1'b1, 2'd1, 1'b0, 16'h0800, 16'h1111, rd, er, lat, en);
        checks++;
        if ({er, en, mem[16'h0800]} !== {1'b1, 1'b0, 8'hAB}) begin
            errors++; $display("FAIL data_write_err: got err=%b en=%b mem=%h want 1 0 ab", er, en, mem[16'h0800]);
        end
        xact(1'b0, 1'b0, 2'd2, 1'b0, 16'h0900, 16'h0, rd, er, lat, en);
        checks++;
        if ({rd, er, lat, en} !== {16'h0000, 1'b1, 32'd1, 1'b0}) begin
            errors++; $display("FAIL fetch_err: got %h err=%b lat=%0d en=%b want 0000 1 1 0", rd, er, lat, en);
        end
        xact(1'b1, 1'b0, 2'd2, 1'b0, 16'h07FF, 16'h0, rd, er, lat, en);
        checks++;
        if ({rd, er, lat} !== {16'hABCD, 1'b0, 32'd3}) begin
            errors++; $display("FAIL last_word_valid: got %h err=%b lat=%0d want abcd 0 3", rd, er, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n; int cyc;
        mem[16'h0100] = 8'hEF; mem[16'h0101] = 8'hBE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        f_req = 1'b1; f_addr = 16'h0010;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 16'h0100;
        double_ack = 0; n = 0; cyc = 0;
        while (n < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (f_ack || d_ack) begin
                checks++;
                if ({d_ack, cyc} !== {n[0], 3 + 4 * n}) begin
                    errors++; $display("FAIL rr_order_%0d: got d_ack=%b cyc=%0d want d_ack=%b cyc=%0d",
                                       n, d_ack, cyc, n[0], 3 + 4 * n);
                end
                checks++;
                if ((d_ack ? d_data : f_data) !== (n[0] ? 16'hBEEF : 16'h1234)) begin
                    errors++; $display("FAIL rr_data_%0d: got %h want %h", n,
                                       d_ack ? d_data : f_data, n[0] ? 16'hBEEF : 16'h1234);
                end
                n++;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (n !== 6) begin errors++; $display("FAIL rr_ack_count: got %0d want 6", n); end
        @(negedge clk);
        checks++;
        if (double_ack !== 0) begin errors++; $display("FAIL double_ack: got %0d want 0", double_ack); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic er; int lat; bit en; int acks;
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0010;
        repeat (2) @(negedge clk);
        reset = 1'b1; f_req = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== 72'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h want 0", all_outs());
        end
        reset = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (f_ack || d_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL reset_mid_stray_ack: got %0d want 0", acks); end
        xact(1'b0, 1'b0, 2'd2, 1'b0, 16'h0010, 16'h0, rd, er, lat, en);
        checks++;
        if ({rd, er, lat} !== {16'h1234, 1'b0, 32'd3}) begin
            errors++; $display("FAIL reset_mid_fresh_fetch: got %h err=%b lat=%0d want 1234 0 3", rd, er, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1; f_req = 1'b0; f_addr = 16'h0; d_req = 1'b0; d_write = 1'b0;
        d_size = 2'd0; d_signed = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        test_reset();
        test_fetch();
        test_byte_reads();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
